// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM:SS clock set controller:
//   - state_e    : edit-mode state encoding, also the o_mode output code
//   - HR/MIN/SEC : bit positions of each digit pair in the blank mask
//   - TICK_HZ    : rate of the i_tick strobe
//   - next_mode  : MODE button step RUN->SET_HR->SET_MIN->SET_SEC->RUN
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_e;

    localparam int HR  = 2;
    localparam int MIN = 1;
    localparam int SEC = 0;

    localparam int TICK_HZ = 10;

    // Ticks per half blink period, giving a 1 Hz blink.
    localparam int BLINK_TICKS = TICK_HZ / 2;

    // The encoding is ordered so one MODE press is a 2-bit increment that
    // wraps from SET_SEC back to RUN.
    function automatic state_e next_mode(input state_e s);
        return state_e'(s + 2'd1);
    endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// -----------------------------------------------------------------------------
// clock_set_controller_if
// Groups the button inputs, tick strobe and counter-chain controls of the
// clock set controller.
//   i_mode      : single-cycle MODE pulse (debounced, edge detected)
//   i_inc_held  : debounced INC level, 1 = pressed
//   i_tick      : free-running single-cycle 10 Hz strobe
//   o_run_en    : 1 Hz pulse generator enable, high only in RUN
//   o_hr_up     : one-cycle hour increment strobe
//   o_min_up    : one-cycle minute increment strobe
//   o_sec_clr   : one-cycle seconds clear strobe
//   o_mode      : current state code (0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC)
//   o_blank     : {hr, min, sec} blank mask, only with CLOCK_SET_BLINK_EN
// Modports: slave = the controller, master = the button/counter side.
// Handshake: there is no valid/ready flow control; every strobe is a
// single-cycle pulse that the receiver must accept in the cycle it is high.
// -----------------------------------------------------------------------------
interface clock_set_controller_if;

    logic       i_mode;
    logic       i_inc_held;
    logic       i_tick;
    logic       o_run_en;
    logic       o_hr_up;
    logic       o_min_up;
    logic       o_sec_clr;
    logic [1:0] o_mode;
`ifdef CLOCK_SET_BLINK_EN
    logic [2:0] o_blank;

    modport slave (
        input  i_mode, i_inc_held, i_tick,
        output o_run_en, o_hr_up, o_min_up, o_sec_clr, o_mode, o_blank
    );

    modport master (
        output i_mode, i_inc_held, i_tick,
        input  o_run_en, o_hr_up, o_min_up, o_sec_clr, o_mode, o_blank
    );
`else
    modport slave (
        input  i_mode, i_inc_held, i_tick,
        output o_run_en, o_hr_up, o_min_up, o_sec_clr, o_mode
    );

    modport master (
        output i_mode, i_inc_held, i_tick,
        input  o_run_en, o_hr_up, o_min_up, o_sec_clr, o_mode
    );
`endif

endinterface

// File: rtl/hold_repeat_timer.sv
// -----------------------------------------------------------------------------
// hold_repeat_timer
// Edge detect and press-and-hold auto-repeat for the INC button. Emits a
// single combinational inc_event pulse; the controller registers it into
// the field strobes.
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_inc_held    : debounced INC level
//   i_tick        : 10 Hz strobe
//   i_clear       : state is changing this cycle (MODE press or timeout)
//   i_in_set      : controller is in one of the SET states
//   i_repeat_en   : controller is in a state that auto-repeats
//   o_inc_event   : one increment is due this cycle
// -----------------------------------------------------------------------------
module hold_repeat_timer #(
    parameter int REPEAT_DELAY = 5,
    parameter int REPEAT_RATE  = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc_held,
    input  logic i_tick,
    input  logic i_clear,
    input  logic i_in_set,
    input  logic i_repeat_en,
    output logic o_inc_event
);

    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    // Hold count values at which the next tick produces a repeat: the first
    // repeat after REPEAT_DELAY ticks, then one every REPEAT_RATE ticks by
    // reloading to REPEAT_DELAY.
    localparam logic [HW-1:0] FIRST_AT = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] NEXT_AT  = HW'(REPEAT_DELAY + REPEAT_RATE - 1);
    localparam logic [HW-1:0] RELOAD   = HW'(REPEAT_DELAY);

    logic          inc_q, inc_d;
    logic          armed_q, armed_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rise;
    logic          rep_evt;

    always_comb begin
        inc_d   = i_inc_held;
        rise    = i_inc_held & ~inc_q;
        rep_evt = armed_q & i_inc_held & i_tick & i_repeat_en &
                  ((hold_q == FIRST_AT) || (hold_q == NEXT_AT));

        hold_d  = hold_q;
        armed_d = armed_q;
        // Repeat is only armed by a press accepted in the current state, so
        // a button still held across a state change stays silent until it
        // is released and pressed again.
        if (i_clear || !i_inc_held || !i_repeat_en) begin
            hold_d  = '0;
            armed_d = 1'b0;
        end else if (rise) begin
            hold_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q && i_tick) begin
            hold_d = (hold_q == NEXT_AT) ? RELOAD : hold_q + 1'b1;
        end

        o_inc_event = ~i_clear & ((rise & i_in_set) | rep_evt);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inc_q   <= 1'b0;
            armed_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            inc_q   <= inc_d;
            armed_q <= armed_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
// Two-button (MODE, INC) set sequencer for the HH:MM:SS clock. MODE steps
// RUN->SET_HR->SET_MIN->SET_SEC->RUN; INC issues a one-cycle strobe into the
// field being edited, with press-and-hold auto-repeat for hours and minutes,
// and an inactivity timeout returns to RUN.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   bus   : clock_set_controller_if.slave (buttons, tick, strobes, mode code)
// Optional: define CLOCK_SET_BLINK_EN to add the o_blank digit blink mask.
// -----------------------------------------------------------------------------
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 100,
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_RATE   = 2
) (
    input logic                   i_clk,
    input logic                   i_rst,
    clock_set_controller_if.slave bus
);

    localparam int IW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_TICKS);

    state_e        state_q, state_d;
    logic          run_en_q, run_en_d;
    logic          hr_up_q, hr_up_d;
    logic          min_up_q, min_up_d;
    logic          sec_clr_q, sec_clr_d;
    logic [IW-1:0] idle_q, idle_d;

    logic          in_set;
    logic          repeat_en;
    logic          timeout;
    logic          clear;
    logic          inc_event;

    assign in_set    = (state_q != RUN);
    assign repeat_en = (state_q == SET_HR) || (state_q == SET_MIN);
    assign timeout   = in_set && (idle_q == IDLE_LIMIT);
    assign clear     = bus.i_mode | timeout;

    hold_repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_hold (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_inc_held  (bus.i_inc_held),
        .i_tick      (bus.i_tick),
        .i_clear     (clear),
        .i_in_set    (in_set),
        .i_repeat_en (repeat_en),
        .o_inc_event (inc_event)
    );

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RUN;
        end else if (bus.i_mode) begin
            state_d = next_mode(state_q);
        end

        // Idle counter: any button activity restarts it; it sits at zero in
        // RUN and is cleared in the cycle the timeout fires.
        idle_d = idle_q;
        if (!in_set || clear || inc_event) begin
            idle_d = '0;
        end else if (bus.i_tick && (idle_q != IDLE_LIMIT)) begin
            idle_d = idle_q + 1'b1;
        end

        run_en_d  = (state_d == RUN);
        hr_up_d   = inc_event && (state_q == SET_HR);
        min_up_d  = inc_event && (state_q == SET_MIN);
        sec_clr_d = inc_event && (state_q == SET_SEC);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= RUN;
            run_en_q  <= 1'b1;
            hr_up_q   <= 1'b0;
            min_up_q  <= 1'b0;
            sec_clr_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            hr_up_q   <= hr_up_d;
            min_up_q  <= min_up_d;
            sec_clr_q <= sec_clr_d;
            idle_q    <= idle_d;
        end
    end

    assign bus.o_run_en  = run_en_q;
    assign bus.o_hr_up   = hr_up_q;
    assign bus.o_min_up  = min_up_q;
    assign bus.o_sec_clr = sec_clr_q;
    assign bus.o_mode    = state_q;

`ifdef CLOCK_SET_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [BW-1:0] vis_q, vis_d;
    logic [2:0]    blank_q, blank_d;

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (bus.i_tick) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // Keeps the edited field visible for BLINK_TICKS ticks after each
        // increment so the user sees the value change.
        vis_d = vis_q;
        if (inc_event) begin
            vis_d = BW'(BLINK_TICKS);
        end else if (bus.i_tick && (vis_q != '0)) begin
            vis_d = vis_q - 1'b1;
        end

        blank_d = 3'b000;
        if (blink_d && (vis_d == '0)) begin
            case (state_d)
                SET_HR:  blank_d[HR]  = 1'b1;
                SET_MIN: blank_d[MIN] = 1'b1;
                SET_SEC: blank_d[SEC] = 1'b1;
                default: blank_d      = 3'b000;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            blink_q <= 1'b0;
            bcnt_q  <= '0;
            vis_q   <= '0;
            blank_q <= 3'b000;
        end else begin
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            vis_q   <= vis_d;
            blank_q <= blank_d;
        end
    end

    assign bus.o_blank = blank_q;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_set_controller
// Self-checking bench for clock_set_controller (default build). Strobes are
// logged by a negedge monitor as {kind, cycle} entries and compared against
// an expected queue built from the button rules: one strobe per accepted
// press, then repeats at hold tick REPEAT_DELAY and every REPEAT_RATE ticks.
// -----------------------------------------------------------------------------
module tb_clock_set_controller;

    localparam int T_TICKS = 100;
    localparam int R_DELAY = 5;
    localparam int R_RATE  = 2;

    localparam logic [1:0] K_HR  = 2'd1;
    localparam logic [1:0] K_MIN = 2'd2;
    localparam logic [1:0] K_SEC = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_set_controller_if bus ();

    clock_set_controller #(
        .TIMEOUT_TICKS (T_TICKS),
        .REPEAT_DELAY  (R_DELAY),
        .REPEAT_RATE   (R_RATE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int model_mode = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    logic p_hr = 1'b0, p_min = 1'b0, p_sec = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_hr  <= 1'b0;
            p_min <= 1'b0;
            p_sec <= 1'b0;
        end else begin
            if (bus.o_hr_up)   got_q.push_back({K_HR,  cyc[29:0]});
            if (bus.o_min_up)  got_q.push_back({K_MIN, cyc[29:0]});
            if (bus.o_sec_clr) got_q.push_back({K_SEC, cyc[29:0]});
            if (($countones({bus.o_hr_up, bus.o_min_up, bus.o_sec_clr}) > 1) ||
                (bus.o_hr_up && p_hr) || (bus.o_min_up && p_min) ||
                (bus.o_sec_clr && p_sec))
                viol <= viol + 1;
            p_hr  <= bus.o_hr_up;
            p_min <= bus.o_min_up;
            p_sec <= bus.o_sec_clr;
        end
    end

    function automatic int sb_first_diff();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (exp_q[i] !== got_q[i]) return i;
        if (exp_q.size() != got_q.size())
            return (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
        return -1;
    endfunction

    function automatic bit repeat_at(input int j);
        return (j == R_DELAY) || (j > R_DELAY && ((j - R_DELAY) % R_RATE) == 0);
    endfunction

    // ---------------- driver tasks ----------------
    // All drivers start and end just after a rising edge.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk1();
    endtask

    task automatic tick();
        bus.i_tick = 1'b1;
        clk1();
        bus.i_tick = 1'b0;
    endtask

    task automatic mode_pulse();
        bus.i_mode = 1'b1;
        clk1();
        bus.i_mode = 1'b0;
        model_mode = (model_mode + 1) % 4;
    endtask

    task automatic goto_mode(input int m);
        while (model_mode != m) mode_pulse();
        clk1();
    endtask

    task automatic press(input logic [1:0] kind, input bit expect_strobe);
        bus.i_inc_held = 1'b1;
        clk1();
        if (expect_strobe) exp_q.push_back({kind, cyc[29:0]});
    endtask

    task automatic release_inc();
        bus.i_inc_held = 1'b0;
        clk1();
    endtask

    task automatic sb_clear();
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(3);
        @(negedge clk);
        total++;
        if (bus.o_mode !== 2'd0) begin
            bad++; $display("FAIL reset_mode: got %0d expected 0", bus.o_mode);
        end
        total++;
        if (bus.o_run_en !== 1'b1) begin
            bad++; $display("FAIL reset_run_en: got %b expected 1", bus.o_run_en);
        end
        total++;
        if ({bus.o_hr_up, bus.o_min_up, bus.o_sec_clr} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes: got %b expected 000",
                            {bus.o_hr_up, bus.o_min_up, bus.o_sec_clr});
        end
        clk1();
        rst = 1'b0;
        idle(2);
        @(negedge clk);
        total++;
        if ({bus.o_mode, bus.o_run_en} !== 3'b001) begin
            bad++; $display("FAIL post_reset: got mode=%0d run_en=%b expected 0/1",
                            bus.o_mode, bus.o_run_en);
        end
        clk1();
    endtask

    task automatic test_mode_cycle();
        for (int i = 0; i < 4; i++) begin
            bus.i_mode = 1'b1;
            @(negedge clk);
            total++;
            if (bus.o_mode !== 2'(model_mode)) begin
                bad++; $display("FAIL mode_latency: got %0d expected %0d", bus.o_mode, model_mode);
            end
            clk1();
            bus.i_mode = 1'b0;
            model_mode = (model_mode + 1) % 4;
            @(negedge clk);
            total++;
            if (bus.o_mode !== 2'(model_mode)) begin
                bad++; $display("FAIL mode_step: got %0d expected %0d", bus.o_mode, model_mode);
            end
            total++;
            if (bus.o_run_en !== (model_mode == 0)) begin
                bad++; $display("FAIL run_en_step: got %b expected %b", bus.o_run_en, model_mode == 0);
            end
            clk1();
        end
    endtask

    task automatic test_hr_single();
        int d;
        goto_mode(1);
        sb_clear();
        press(K_HR, 1'b1);
        release_inc();
        idle(3);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL hr_single: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
        goto_mode(0);
        sb_clear();
        press(K_HR, 1'b0);
        for (int j = 0; j < 8; j++) begin tick(); clk1(); end
        release_inc();
        idle(3);
        total++;
        if (got_q.size() != 0) begin
            bad++; $display("FAIL run_no_strobe: got %0d strobes expected 0", got_q.size());
        end
    endtask

    task automatic test_min_repeat();
        int d;
        goto_mode(2);
        sb_clear();
        press(K_MIN, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (repeat_at(j)) exp_q.push_back({K_MIN, cyc[29:0]});
            clk1();
        end
        release_inc();
        for (int j = 0; j < 4; j++) begin tick(); clk1(); end
        idle(2);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL min_repeat: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
        total++;
        if (got_q.size() != 5) begin
            bad++; $display("FAIL min_repeat_count: got %0d expected 5", got_q.size());
        end
    endtask

    task automatic test_sec_once();
        int d;
        goto_mode(3);
        sb_clear();
        press(K_SEC, 1'b1);
        for (int j = 0; j < 20; j++) begin tick(); clk1(); end
        release_inc();
        idle(3);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL sec_once: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_mode_inc_same();
        int d;
        goto_mode(1);
        sb_clear();
        bus.i_mode = 1'b1;
        bus.i_inc_held = 1'b1;
        clk1();
        bus.i_mode = 1'b0;
        model_mode = 2;
        for (int j = 0; j < 8; j++) begin tick(); clk1(); end
        @(negedge clk);
        total++;
        if (bus.o_mode !== 2'd2) begin
            bad++; $display("FAIL same_cycle_mode: got %0d expected 2", bus.o_mode);
        end
        total++;
        if (got_q.size() != 0) begin
            bad++; $display("FAIL same_cycle_suppress: got %0d strobes expected 0", got_q.size());
        end
        clk1();
        release_inc();
        press(K_MIN, 1'b1);
        release_inc();
        idle(3);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL repress: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int d;
        goto_mode(0);
        goto_mode(2);
        for (int j = 1; j <= T_TICKS - 1; j++) begin tick(); clk1(); end
        @(negedge clk);
        total++;
        if (bus.o_mode !== 2'd2) begin
            bad++; $display("FAIL timeout_early: got %0d expected 2", bus.o_mode);
        end
        clk1();
        tick();
        @(negedge clk);
        total++;
        if (bus.o_mode !== 2'd2) begin
            bad++; $display("FAIL timeout_edge: got %0d expected 2", bus.o_mode);
        end
        clk1();
        @(negedge clk);
        total++;
        if ({bus.o_mode, bus.o_run_en} !== 3'b001) begin
            bad++; $display("FAIL timeout_fire: got mode=%0d run_en=%b expected 0/1",
                            bus.o_mode, bus.o_run_en);
        end
        model_mode = 0;
        clk1();
        goto_mode(2);
        sb_clear();
        for (int j = 1; j <= T_TICKS - 1; j++) begin tick(); clk1(); end
        press(K_MIN, 1'b1);
        release_inc();
        for (int j = 0; j < 51; j++) begin tick(); clk1(); end
        @(negedge clk);
        total++;
        if (bus.o_mode !== 2'd2) begin
            bad++; $display("FAIL timeout_restart: got %0d expected 2", bus.o_mode);
        end
        clk1();
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL timeout_press: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d;
        goto_mode(0);
        goto_mode(2);
        sb_clear();
        press(K_MIN, 1'b1);
        for (int j = 1; j <= R_DELAY; j++) begin clk1(); tick(); end
        total++;
        if (bus.o_min_up !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre: got min_up=%b expected 1", bus.o_min_up);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.o_hr_up, bus.o_min_up, bus.o_sec_clr} !== 3'b000) begin
            bad++; $display("FAIL reset_mid_strobes: got %b expected 000",
                            {bus.o_hr_up, bus.o_min_up, bus.o_sec_clr});
        end
        total++;
        if ({bus.o_mode, bus.o_run_en} !== 3'b001) begin
            bad++; $display("FAIL reset_mid_state: got mode=%0d run_en=%b expected 0/1",
                            bus.o_mode, bus.o_run_en);
        end
        bus.i_inc_held = 1'b0;
        model_mode = 0;
        idle(2);
        rst = 1'b0;
        idle(2);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL reset_mid_sb: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int d, target, n;
        logic [1:0] kind;
        sb_clear();
        for (int r = 0; r < 8; r++) begin
            target = $urandom_range(1, 3);
            kind = 2'(target);
            goto_mode(target);
            press(kind, 1'b1);
            n = $urandom_range(0, 14);
            for (int j = 1; j <= n; j++) begin
                repeat ($urandom_range(0, 2)) clk1();
                tick();
                if (target != 3 && repeat_at(j)) exp_q.push_back({kind, cyc[29:0]});
            end
            release_inc();
            idle($urandom_range(1, 3));
            goto_mode(0);
        end
        idle(2);
        d = sb_first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL random_hold: diff at %0d got_n=%0d exp_n=%0d", d, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL strobe_exclusive: got %0d violations expected 0", viol);
        end
    endtask

    initial begin
        bus.i_mode     = 1'b0;
        bus.i_inc_held = 1'b0;
        bus.i_tick     = 1'b0;
        test_reset();
        test_mode_cycle();
        test_hr_single();
        test_min_repeat();
        test_sec_once();
        test_mode_inc_same();
        test_timeout();
        test_reset_mid();
        test_random();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
